// File: rtl/regfile_pkg.sv
// Shared types, defaults and byte-merge helper for the 2-read/1-write register file.
package regfile_pkg;

    localparam int unsigned DefWidth = 64;
    localparam int unsigned DefDepth = 8;

    // byte_merge works on a fixed maximum width; callers extend/truncate to their WIDTH.
    localparam int unsigned MaxWidth = 1024;
    localparam int unsigned MaxBytes = MaxWidth / 8;

    typedef logic [0:0] state_t;
    localparam state_t IDLE  = 1'b0;
    localparam state_t CLEAR = 1'b1;

    function automatic logic [MaxWidth-1:0] byte_merge(
        input logic [MaxWidth-1:0] old_val,
        input logic [MaxWidth-1:0] new_val,
        input logic [MaxBytes-1:0] be
    );
        logic [MaxWidth-1:0] res;
        res = old_val;
        for (int b = 0; b < int'(MaxBytes); b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// Registered read port; same-edge write and clear results are forwarded into rdata.
module regfile_rd_port #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned AW    = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    input  logic [WIDTH-1:0] stored_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             clr_en_i,
    input  logic [AW-1:0]    clr_addr_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             rvalid_o
);

    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;

    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = re_i;
        if (re_i) begin
            if (clr_en_i && (clr_addr_i == raddr_i)) begin
                rdata_d = '0;
            end else if (wr_en_i && (waddr_i == raddr_i)) begin
                rdata_d = wr_data_i;
            end else begin
                rdata_d = stored_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;

endmodule

// File: rtl/regfile_2r1w.sv
// WIDTH x DEPTH register file: byte-masked write, two bypassed read ports, clear sweep.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned DEPTH = DefDepth,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [WIDTH-1:0]       wdata,
    input  logic [WIDTH/8-1:0]     wbe,
    input  logic                   re0,
    input  logic [AW-1:0]          raddr0,
    output logic [WIDTH-1:0]       rdata0,
    output logic                   rvalid0,
    input  logic                   re1,
    input  logic [AW-1:0]          raddr1,
    output logic [WIDTH-1:0]       rdata1,
    output logic                   rvalid1,
    input  logic                   clr,
    output logic                   busy,
    output logic                   wr_drop,
    output logic [WIDTH*DEPTH-1:0] q_all
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             wr_drop_q, wr_drop_d;
    logic             wr_en, clr_en;
    logic [WIDTH-1:0] wr_merged;

    assign wr_en     = we && (state_q == IDLE);
    assign clr_en    = (state_q == CLEAR);
    assign wr_merged = WIDTH'(byte_merge(MaxWidth'(mem_q[waddr]), MaxWidth'(wdata),
                                         MaxBytes'(wbe)));

    // Writes only happen in IDLE and clears only in CLEAR, so they never collide.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_en) begin
            mem_d[waddr] = wr_merged;
        end
        if (clr_en) begin
            mem_d[cnt_q] = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_drop_d = we && (state_q == CLEAR);
        case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_drop_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_drop_q <= wr_drop_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign busy    = (state_q == CLEAR);
    assign wr_drop = wr_drop_q;

    // Entry 0 occupies the most significant slice.
    for (genvar i = 0; i < int'(DEPTH); i++) begin : g_q_all
        assign q_all[WIDTH*(DEPTH-i)-1 -: WIDTH] = mem_q[i];
    end

    regfile_rd_port #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_rd_port0 (
        .clk_i      (clk),
        .rst_i      (rst),
        .re_i       (re0),
        .raddr_i    (raddr0),
        .stored_i   (mem_q[raddr0]),
        .wr_en_i    (wr_en),
        .waddr_i    (waddr),
        .wr_data_i  (wr_merged),
        .clr_en_i   (clr_en),
        .clr_addr_i (cnt_q),
        .rdata_o    (rdata0),
        .rvalid_o   (rvalid0)
    );

    regfile_rd_port #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_rd_port1 (
        .clk_i      (clk),
        .rst_i      (rst),
        .re_i       (re1),
        .raddr_i    (raddr1),
        .stored_i   (mem_q[raddr1]),
        .wr_en_i    (wr_en),
        .waddr_i    (waddr),
        .wr_data_i  (wr_merged),
        .clr_en_i   (clr_en),
        .clr_addr_i (cnt_q),
        .rdata_o    (rdata1),
        .rvalid_o   (rvalid1)
    );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w: read expectations queued at issue, checked on rvalid.
module tb_regfile_2r1w;

    localparam int unsigned WIDTH = 64;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;
    localparam int unsigned NB    = 8;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   we = 1'b0;
    logic [AW-1:0]          waddr = '0;
    logic [WIDTH-1:0]       wdata = '0;
    logic [NB-1:0]          wbe = '0;
    logic                   re0 = 1'b0;
    logic [AW-1:0]          raddr0 = '0;
    logic                   re1 = 1'b0;
    logic [AW-1:0]          raddr1 = '0;
    logic                   clr = 1'b0;
    logic [WIDTH-1:0]       rdata0, rdata1;
    logic                   rvalid0, rvalid1, busy, wr_drop;
    logic [WIDTH*DEPTH-1:0] q_all;

    logic [WIDTH-1:0] m [DEPTH];
    logic [WIDTH-1:0] exp0 [$];
    logic [WIDTH-1:0] exp1 [$];
    int n_checks = 0;
    int n_errors = 0;

    regfile_2r1w #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .re0(re0), .raddr0(raddr0), .rdata0(rdata0), .rvalid0(rvalid0),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1), .rvalid1(rvalid1),
        .clr(clr), .busy(busy), .wr_drop(wr_drop), .q_all(q_all)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n,
                                          input logic [7:0] be);
        logic [63:0] r;
        r = o;
        for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    function automatic logic [63:0] entry(input int i);
        return q_all[64*(DEPTH-i)-1 -: 64];
    endfunction

    task automatic idle_inputs();
        we = 1'b0; wbe = '0; wdata = '0; re0 = 1'b0; re1 = 1'b0; clr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop the oldest expectation for each port whose rvalid is high.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst && rvalid0) begin
            n_checks++;
            if (exp0.size() == 0) begin
                n_errors++;
                $display("FAIL rd0_unexpected: rvalid0=1 rdata0=%h, no read issued", rdata0);
            end else begin
                e = exp0.pop_front();
                if (rdata0 !== e) begin
                    n_errors++;
                    $display("FAIL rd0_data: got %h expected %h", rdata0, e);
                end
            end
        end
        if (!rst && rvalid1) begin
            n_checks++;
            if (exp1.size() == 0) begin
                n_errors++;
                $display("FAIL rd1_unexpected: rvalid1=1 rdata1=%h, no read issued", rdata1);
            end else begin
                e = exp1.pop_front();
                if (rdata1 !== e) begin
                    n_errors++;
                    $display("FAIL rd1_data: got %h expected %h", rdata1, e);
                end
            end
        end
    end

    task automatic test_reset();
        idle_inputs();
        #1 rst = 1'b1;
        #2;
        n_checks++;
        if (q_all !== '0) begin n_errors++; $display("FAIL reset_q_all: got %h expected 0", q_all); end
        n_checks++;
        if ({busy, wr_drop, rvalid0, rvalid1} !== 4'b0) begin
            n_errors++;
            $display("FAIL reset_flags: busy/wr_drop/rvalid0/rvalid1 got %b expected 0000",
                     {busy, wr_drop, rvalid0, rvalid1});
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) m[i] = '0;
    endtask

    task automatic test_write_read();
        we = 1'b1; waddr = 3; wdata = 64'h1122334455667788; wbe = 8'hFF;
        tick();
        m[3] = merge(m[3], wdata, wbe);
        we = 1'b0;
        n_checks++;
        if (entry(3) !== 64'h1122334455667788) begin
            n_errors++; $display("FAIL wr_full_q_all: got %h expected 1122334455667788", entry(3));
        end
        re0 = 1'b1; raddr0 = 3; exp0.push_back(m[3]);
        tick();
        re0 = 1'b0;
        n_checks++;
        if (rvalid0 !== 1'b1) begin n_errors++; $display("FAIL rd_rvalid_high: got %b expected 1", rvalid0); end
        tick();
        n_checks++;
        if (rvalid0 !== 1'b0 || rdata0 !== 64'h1122334455667788) begin
            n_errors++;
            $display("FAIL rd_hold: rvalid0=%b rdata0=%h expected 0 / 1122334455667788",
                     rvalid0, rdata0);
        end
    endtask

    task automatic test_partial();
        we = 1'b1; waddr = 5; wdata = 64'hAAAAAAAAAAAAAAAA; wbe = 8'hFF;
        tick();
        m[5] = merge(m[5], wdata, wbe);
        wdata = 64'h0; wbe = 8'h0F;
        tick();
        m[5] = merge(m[5], wdata, wbe);
        n_checks++;
        if (entry(5) !== 64'hAAAAAAAA00000000) begin
            n_errors++; $display("FAIL partial_q_all: got %h expected aaaaaaaa00000000", entry(5));
        end
        wdata = '1; wbe = 8'h00;
        tick();
        we = 1'b0;
        n_checks++;
        if (entry(5) !== m[5] || wr_drop !== 1'b0) begin
            n_errors++;
            $display("FAIL noop_write: entry5=%h wr_drop=%b expected %h / 0", entry(5), wr_drop, m[5]);
        end
        re1 = 1'b1; raddr1 = 5; exp1.push_back(64'hAAAAAAAA00000000);
        tick();
        re1 = 1'b0;
    endtask

    task automatic test_bypass();
        we = 1'b1; waddr = 2; wdata = 64'hDEAD_BEEF_0000_0001; wbe = 8'hFF;
        re0 = 1'b1; raddr0 = 2; re1 = 1'b1; raddr1 = 2;
        exp0.push_back(64'hDEADBEEF00000001);
        exp1.push_back(64'hDEADBEEF00000001);
        tick();
        m[2] = merge(m[2], wdata, wbe);
        idle_inputs();
        re0 = 1'b1; raddr0 = 3; re1 = 1'b1; raddr1 = 5;
        exp0.push_back(m[3]);
        exp1.push_back(m[5]);
        tick();
        idle_inputs();
    endtask

    task automatic test_clear();
        int nbusy;
        logic ok;
        for (int k = 0; k < int'(DEPTH); k++) begin
            we = 1'b1; waddr = AW'(k); wdata = {8{8'(k + 1)}}; wbe = 8'hFF;
            tick();
            m[k] = merge(m[k], wdata, wbe);
        end
        idle_inputs();
        ok = 1'b1;
        for (int k = 0; k < int'(DEPTH); k++) if (entry(k) !== m[k]) ok = 1'b0;
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL fill: q_all got %h", q_all); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        nbusy = 0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (busy) nbusy++;
            if (k == 1) begin we = 1'b1; waddr = 0; wdata = '1; wbe = 8'hFF; end
            if (k == 3) clr = 1'b1;
            if (k == 4) begin
                re0 = 1'b1; raddr0 = 4; exp0.push_back(64'h0);
                re1 = 1'b1; raddr1 = 6; exp1.push_back(m[6]);
            end
            tick();
            idle_inputs();
            m[k] = '0;
            n_checks++;
            if (entry(k) !== 64'h0) begin
                n_errors++; $display("FAIL sweep_zero_%0d: got %h expected 0", k, entry(k));
            end
            if (k < int'(DEPTH) - 1) begin
                n_checks++;
                if (entry(k + 1) !== m[k + 1]) begin
                    n_errors++;
                    $display("FAIL sweep_early_%0d: got %h expected %h", k + 1, entry(k + 1), m[k + 1]);
                end
            end
            if (k == 1) begin
                n_checks++;
                if (wr_drop !== 1'b1 || entry(0) !== 64'h0) begin
                    n_errors++;
                    $display("FAIL wr_drop: wr_drop=%b entry0=%h expected 1 / 0", wr_drop, entry(0));
                end
            end
            if (k == 2) begin
                n_checks++;
                if (wr_drop !== 1'b0) begin n_errors++; $display("FAIL wr_drop_pulse: got %b expected 0", wr_drop); end
            end
        end
        n_checks++;
        if (busy !== 1'b0 || nbusy != int'(DEPTH)) begin
            n_errors++;
            $display("FAIL sweep_len: busy=%b cycles=%0d expected 0 / %0d", busy, nbusy, DEPTH);
        end
    endtask

    task automatic test_clr_write();
        int cyc;
        clr = 1'b1; we = 1'b1; waddr = 0; wdata = 64'h5A5A_0000_1234_5678; wbe = 8'hFF;
        tick();
        m[0] = merge(m[0], wdata, wbe);
        idle_inputs();
        n_checks++;
        if (entry(0) !== 64'h5A5A000012345678 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL clr_write_lands: entry0=%h busy=%b expected 5a5a000012345678 / 1",
                     entry(0), busy);
        end
        re0 = 1'b1; raddr0 = 0; exp0.push_back(64'h0);
        tick();
        re0 = 1'b0;
        m[0] = '0;
        n_checks++;
        if (entry(0) !== 64'h0) begin n_errors++; $display("FAIL clr_write_zeroed: got %h expected 0", entry(0)); end
        cyc = 0;
        while (busy && cyc < 20) begin tick(); cyc++; end
        n_checks++;
        if (busy !== 1'b0 || q_all !== '0) begin
            n_errors++; $display("FAIL clr_write_done: busy=%b q_all=%h expected 0 / 0", busy, q_all);
        end
    endtask

    task automatic test_reset_mid_sweep();
        we = 1'b1; waddr = 6; wdata = 64'h0123456789ABCDEF; wbe = 8'hFF;
        tick();
        m[6] = merge(m[6], wdata, wbe);
        idle_inputs();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick(); tick(); tick();
        n_checks++;
        if (busy !== 1'b1 || entry(6) !== m[6]) begin
            n_errors++;
            $display("FAIL mid_sweep_state: busy=%b entry6=%h expected 1 / %h", busy, entry(6), m[6]);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || q_all !== '0 || wr_drop !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: busy=%b wr_drop=%b q_all=%h expected 0 / 0 / 0",
                     busy, wr_drop, q_all);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) m[i] = '0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || q_all !== '0) begin
            n_errors++; $display("FAIL post_reset_idle: busy=%b q_all=%h expected 0 / 0", busy, q_all);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_partial();
        test_bypass();
        test_clear();
        test_clr_write();
        test_reset_mid_sweep();
        tick();
        n_checks++;
        if (exp0.size() != 0 || exp1.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: pending port0=%0d port1=%0d expected 0 / 0",
                     exp0.size(), exp1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Parametrised successor of the 8x64 single-write register file.
- Generic WIDTH x DEPTH storage with:
  - one byte-masked write port;
  - two independent registered read ports with write-to-read bypass;
  - a multi-cycle clear sweep.
- A flat dump bus of all entries is kept for debug/observation, with entry 0 in the MSBs.
- Sits in the datapath as the architectural register store feeding two-operand execution units.

Parameters:
- WIDTH, 64, entry width in bits; must be a multiple of 8.
- DEPTH, 8, number of entries; power of 2, at least 2.
- AW, $clog2(DEPTH), address width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- we  input  1  write enable.
- waddr  input  AW  write address.
- wdata  input  WIDTH  write data.
- wbe  input  WIDTH/8  byte enables; bit b covers wdata[8b+7:8b].
- re0  input  1  read request, port 0.
- raddr0  input  AW  read address, port 0.
- rdata0  output  WIDTH  registered read data, port 0.
- rvalid0  output  1  rdata0 updated this cycle.
- re1, raddr1, rdata1, rvalid1: same as port 0, for port 1.
- clr  input  1  start clear sweep.
- busy  output  1  clear sweep in progress.
- wr_drop  output  1  one-cycle pulse: a write was rejected.
- q_all  output  WIDTH*DEPTH  flat dump; entry i at [WIDTH*(DEPTH-i)-1 : WIDTH*(DEPTH-i-1)].

Behaviour:
- Reset (rst=1, asynchronous), effective immediately:
  - all entries = 0;
  - rdata0/1 = 0, rvalid0/1 = 0;
  - busy = 0, wr_drop = 0;
  - sweep counter = 0, FSM = IDLE.
- Reset asserted mid-sweep aborts the sweep; everything reads 0.
- Write: at a posedge with we=1 and FSM=IDLE, entry[waddr] takes wdata on bytes where wbe=1; other bytes are kept. wbe=0 gives a legal no-op write (no wr_drop).
- Write with we=1 while busy=1: entry unchanged; wr_drop=1 for the following cycle.
- Read latency is 1 cycle. At a posedge with reN=1:
  - rdataN <= the post-edge value of entry[raddrN];
  - rvalidN <= 1.
- With reN=0: rvalidN <= 0 and rdataN holds its last value.
- Bypass, same-edge write to raddrN: rdataN returns the byte-merged new value, not the old contents.
- Both ports may read the same or different addresses in the same cycle, with no conflict.
- FSM state IDLE:
  - clr=1 -> CLEAR;
  - counter <= 0;
  - busy=1 after that edge.
- A write presented in the same cycle as clr is performed, because the FSM is still IDLE at that edge.
- FSM state CLEAR:
  - each posedge zeroes entry[counter] and increments counter;
  - at counter = DEPTH-1 the entry is zeroed, FSM -> IDLE, busy=0 after that edge.
  - The sweep therefore occupies exactly DEPTH edges after the clr edge.
- clr=1 while CLEAR: ignored; the sweep is not restarted.
- Read during CLEAR is allowed and returns current contents. A read of the entry zeroed at the same edge returns 0 (clear takes part in the bypass path).
- Counter wraps naturally; it is never compared beyond DEPTH-1.
- q_all is a continuous view of storage, updating on the same edge as the storage.

Decomposition:
- Package regfile_pkg:
  - state typedef {IDLE, CLEAR};
  - default WIDTH/DEPTH constants;
  - function byte_merge(old, new, be).
- Sub-module regfile_rd_port: registered read port with write/clear bypass; instantiated twice (port 0 and port 1).
- Storage, write logic, sweep FSM and q_all packing stay in the top level.

Test Plan:
- Reset then dump -> q_all=0, busy=0, rvalid0/1=0. Then write 64'h1122334455667788 to addr 3 with wbe=8'hFF, then re0 addr 3 -> next cycle rdata0=64'h1122334455667788, rvalid0=1.
- Partial write: entry 5 = 64'hAAAAAAAAAAAAAAAA, then write 64'h0 with wbe=8'h0F -> entry 5 = 64'hAAAAAAAA00000000 in both q_all and rdata1.
- Bypass: in the same cycle, write addr 2 = 64'hDEAD_BEEF_0000_0001 with wbe=8'hFF, re0 addr 2, re1 addr 2 -> next cycle rdata0 = rdata1 = 64'hDEADBEEF00000001.
- Clear sweep, all entries nonzero:
  - pulse clr -> busy high for exactly DEPTH=8 cycles, entry k zeroed on the k-th edge;
  - we during busy -> wr_drop=1 next cycle, entry unchanged (0);
  - clr again mid-sweep -> sweep length still 8.
- clr and write to addr 0 in the same cycle -> write lands, then is zeroed on the first sweep edge; read of addr 0 at that edge returns 0.
- Reset asserted 3 cycles into the sweep -> busy=0 and q_all=0 immediately, without waiting for a clock edge.
